// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 64-bit execute-stage ALU between N_REQ requesters.
// One op in flight. Requests use valid/ready. The registered response can fire and re-accept in one cycle.

module alu_arbiter_alu #(
  parameter int ALUOP_WIDTH = 5
) (
  input  logic [63:0]            a,
  input  logic [63:0]            b,
  input  logic [ALUOP_WIDTH-1:0] op,
  output logic [63:0]            data,
  output logic                   illegal
);
  logic [31:0] op_x;
  logic [31:0] word;

  assign op_x = 32'(op);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    data    = '0;
    illegal = 1'b0;
    word    = '0;
    case (op_x)
      32'd0:  data = a + b;
      32'd1:  data = a - b;
      32'd2:  data = a & b;
      32'd3:  data = a | b;
      32'd4:  data = a ^ b;
      32'd5:  data = {63'b0, $signed(a) < $signed(b)};
      32'd6:  data = {63'b0, a < b};
      32'd7:  data = a << b[5:0];
      32'd8:  data = a >> b[5:0];
      32'd9:  data = 64'($signed(a) >>> b[5:0]);
      32'd10: word = a[31:0] + b[31:0];
      32'd11: word = a[31:0] - b[31:0];
      32'd12: word = a[31:0] << b[4:0];
      32'd13: word = a[31:0] >> b[4:0];
      32'd14: word = 32'($signed(a[31:0]) >>> b[4:0]);
      32'd20: data = b;
      default: illegal = 1'b1;
    endcase
    // The word ops (10..14) sign-extend bit 31 of the 32-bit result.
    if (op_x >= 32'd10 && op_x <= 32'd14) data = {{32{word[31]}}, word};
  end
endmodule

module alu_arbiter #(
  parameter int N_REQ       = 2,
  parameter int ALUOP_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*64-1:0]          req_a,
  input  logic [N_REQ*64-1:0]          req_b,
  input  logic [N_REQ*ALUOP_WIDTH-1:0] req_op,
  output logic [N_REQ-1:0]             resp_valid,
  output logic [63:0]                  resp_data,
  output logic                         resp_illegal,
  input  logic [N_REQ-1:0]             resp_ready,
  output logic                         busy
);
  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic {IDLE, RESP} state_t;

  state_t               state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     owner;
  logic [N_REQ-1:0]     grant;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     next_ptr;
  int                   cand;
  logic                 resp_fire;
  logic                 can_accept;
  logic                 accept;
  logic [63:0]          alu_data;
  logic                 alu_illegal;

  // Scan from the lowest priority slot down, so the last hit is the first valid requester at or after rr_ptr.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = (int'(rr_ptr) + k) % N_REQ;
      if (req_valid[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  assign busy       = (state == RESP);
  assign resp_valid = busy ? (N_REQ'(1) << owner) : '0;
  assign resp_fire  = busy & resp_ready[owner];
  assign can_accept = (state == IDLE) | resp_fire;
  assign req_ready  = grant & {N_REQ{can_accept}};
  assign accept     = can_accept & (|req_valid);
  assign next_ptr   = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

  alu_arbiter_alu #(.ALUOP_WIDTH(ALUOP_WIDTH)) u_alu (
    .a       (req_a[grant_idx*64 +: 64]),
    .b       (req_b[grant_idx*64 +: 64]),
    .op      (req_op[grant_idx*ALUOP_WIDTH +: ALUOP_WIDTH]),
    .data    (alu_data),
    .illegal (alu_illegal)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      resp_data    <= '0;
      resp_illegal <= 1'b0;
    end else if (accept) begin
      state        <= RESP;
      rr_ptr       <= next_ptr;
      owner        <= grant_idx;
      resp_data    <= alu_data;
      resp_illegal <= alu_illegal;
    end else if (resp_fire) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter (N_REQ=2).
// It checks the DUT against an abstract transaction model: pointer, held response and an arithmetic ALU reference.

module tb_alu_arbiter;
  localparam int N  = 2;
  localparam int OW = 5;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*64-1:0] req_a = '0;
  logic [N*64-1:0] req_b = '0;
  logic [N*OW-1:0] req_op = '0;
  logic [N-1:0]    resp_valid;
  logic [63:0]     resp_data;
  logic            resp_illegal;
  logic [N-1:0]    resp_ready = '0;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Abstract model state.
  bit          m_busy;
  int          m_owner;
  int          m_ptr;
  logic [63:0] m_data;
  bit          m_illegal;
  logic [N-1:0] m_acc;

  always #5 clk = ~clk;

  alu_arbiter #(.N_REQ(N), .ALUOP_WIDTH(OW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_illegal (resp_illegal),
    .resp_ready   (resp_ready),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sext32(input logic [63:0] x);
    return {{32{x[31]}}, x[31:0]};
  endfunction

  function automatic logic [63:0] ref_alu(input int op, input logic [63:0] a, input logic [63:0] b);
    int                 sh;
    int                 shw;
    logic signed [31:0] lo;
    sh  = int'(b[5:0]);
    shw = int'(b[4:0]);
    lo  = a[31:0];
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      6:  return (a < b) ? 64'd1 : 64'd0;
      7:  return a << sh;
      8:  return a >> sh;
      9:  return 64'($signed(a) >>> sh);
      10: return sext32(a + b);
      11: return sext32(a - b);
      12: return sext32(a << shw);
      13: return sext32({32'b0, a[31:0]} >> shw);
      14: return sext32(64'(lo >>> shw));
      20: return b;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [N-1:0] model_grant();
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return N'(1) << ((m_ptr + k) % N);
    end
    return '0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_data = '0; m_illegal = 0; m_acc = '0;
  endtask

  // Called at a negedge with inputs already driven: check outputs, cross the rising edge, advance the model.
  task automatic step(input string tag);
    logic [N-1:0] g;
    bit           fire;
    bit           can;
    int           op;
    #1;
    fire = m_busy && resp_ready[m_owner];
    can  = !m_busy || fire;
    g    = model_grant();
    check({tag, " req_ready"}, 64'(req_ready), can ? 64'(g) : 64'd0);
    check({tag, " resp_valid"}, 64'(resp_valid), m_busy ? (64'd1 << m_owner) : 64'd0);
    check({tag, " busy"}, 64'(busy), 64'(m_busy));
    if (m_busy) begin
      check({tag, " resp_data"}, resp_data, m_data);
      check({tag, " resp_illegal"}, 64'(resp_illegal), 64'(m_illegal));
    end
    @(posedge clk);
    m_acc = can ? g : '0;
    if (can && g != '0) begin
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          op        = int'(req_op[i*OW +: OW]);
          m_data    = ref_alu(op, req_a[i*64 +: 64], req_b[i*64 +: 64]);
          m_illegal = !(op <= 14 || op == 20);
          m_owner   = i;
          m_ptr     = (i + 1) % N;
        end
      end
      m_busy = 1;
    end else if (fire) begin
      m_busy = 0;
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input int op, input logic [63:0] a, input logic [63:0] b);
    req_op[i*OW +: OW] = OW'(op);
    req_a[i*64 +: 64]  = a;
    req_b[i*64 +: 64]  = b;
  endtask

  // Issue one op on requester i alone, then check its response against a fixed value.
  task automatic single(input string tag, input int i, input int op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input bit exp_ill);
    set_req(i, op, a, b);
    req_valid  = N'(1) << i;
    resp_ready = '1;
    step(tag);
    req_valid = '0;
    #1;
    check({tag, " data"}, resp_data, exp);
    check({tag, " illegal"}, 64'(resp_illegal), 64'(exp_ill));
    step({tag, " drain"});
  endtask

  initial begin
    int op;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset resp_valid", 64'(resp_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset resp_data", resp_data, 64'd0);
    check("reset resp_illegal", 64'(resp_illegal), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // T1: single request, same-cycle ready, 1-cycle latency.
    set_req(0, 0, 64'd5, 64'd7);
    req_valid  = 2'b01;
    resp_ready = 2'b11;
    #1 check("t1 req_ready", 64'(req_ready), 64'd1);
    step("t1");
    req_valid = '0;
    #1;
    check("t1 resp_valid", 64'(resp_valid), 64'd1);
    check("t1 resp_data", resp_data, 64'd12);
    check("t1 resp_illegal", 64'(resp_illegal), 64'd0);
    step("t1 drain");

    // T2: fairness from rr_ptr=0 with both requesters valid.
    reset_n = 1'b0; model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    set_req(0, 0, 64'd1, 64'd1);
    set_req(1, 1, 64'd3, 64'd5);
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2 grant order", 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      if (k > 0)
        check("t2 resp_data", resp_data, (k % 2 == 1) ? 64'd2 : 64'hFFFF_FFFF_FFFF_FFFE);
      step("t2");
    end

    // T3: backpressure holds everything stable, release fires and re-accepts together.
    resp_ready = 2'b00;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3 req_ready held", 64'(req_ready), 64'd0);
      check("t3 busy", 64'(busy), 64'd1);
      step("t3");
    end
    resp_ready = 2'b11;
    #1 check("t3 release accept", 64'(req_ready), 64'd1);
    step("t3 release");
    req_valid = '0;
    step("t3 drain");
    step("t3 idle");

    // T4 / T5: word op, illegal op, shift-amount masking.
    single("t4 addw", 0, 10, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b0);
    single("t4 op15", 1, 15, 64'd9, 64'd9, 64'd0, 1'b1);
    single("t4 passb", 0, 20, 64'd1, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b0);
    single("t5 sll", 0, 7, 64'd1, 64'h41, 64'd2, 1'b0);
    single("t5 sllw", 1, 12, 64'd1, 64'h3F, 64'hFFFF_FFFF_8000_0000, 1'b0);

    // T6: async reset while a response is held.
    set_req(0, 0, 64'd1, 64'd2);
    req_valid  = 2'b01;
    resp_ready = 2'b00;
    step("t6 accept");
    req_valid = '0;
    #2;
    reset_n = 1'b0;
    #1;
    check("t6 async resp_valid", 64'(resp_valid), 64'd0);
    check("t6 async busy", 64'(busy), 64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    resp_ready = 2'b11;
    step("t6 quiet0");
    step("t6 quiet1");
    req_valid = 2'b11;
    #1 check("t6 first grant", 64'(req_ready), 64'd1);
    step("t6 grant");

    // Random phase: requesters keep a pending payload stable until it is accepted.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || m_acc[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          case ($urandom_range(0, 5))
            0:       op = $urandom_range(15, 31);
            1:       op = 20;
            default: op = $urandom_range(0, 14);
          endcase
          set_req(i, op, {$urandom, $urandom},
                  ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, 127)) : {$urandom, $urandom});
        end
      end
      resp_ready = N'($urandom_range(0, (1 << N) - 1));
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
